fetch_unit: RTL

- Instruction-fetch stage of the 32-bit RISC core.
- Owns the program counter and issues word requests to instruction memory over a req/ready handshake.
- Presents one fetched instruction at a time to decode in a stallable output slot.
- Produces if_pc_plus4, which feeds the input_a leg of the downstream next-PC selector_2x1; the branch/jump target drives input_b.

---
 rtl/fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: owns the PC, issues imem word requests, holds one instruction for decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        discard;

  logic        slot_free;
  logic        fire;
  logic        accept;
  logic        consume;
  logic [31:0] redirect_target;
  logic        unused_redirect_low;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  assign slot_free = !if_valid || !stall;
  assign consume   = if_valid && !stall;

  // A WAIT request is never withdrawn, so the address comes from the latched
  // copy there; pc may already have moved on to a redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      FETCH: imem_req = slot_free && !redirect_valid;
      WAIT: begin
        imem_req  = 1'b1;
        imem_addr = req_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign fire   = imem_req && imem_ready;
  assign accept = fire && !discard && !redirect_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      discard     <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_instr    <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_req && !imem_ready) begin
            state    <= WAIT;
            req_addr <= pc;
          end
        end
        WAIT: begin
          if (imem_ready) begin
            state   <= FETCH;
            discard <= 1'b0;
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        if_instr    <= imem_rdata;
        if_pc       <= pc;
        if_pc_plus4 <= pc + 32'd4;
        if_valid    <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (consume) begin
        if_valid <= 1'b0;
      end

      // Redirect overrides both the accept and a stalled slot.
      if (redirect_valid) begin
        pc       <= redirect_target;
        if_valid <= 1'b0;
      end
    end
  end

endmodule
